// File: rtl/dcache_mem.sv
// Memory-side line engine for the data cache: captures a dirty victim line and writes it to
// external nibble memory, then fetches the missing line and bursts it into the cache.
module dcache_mem #(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req,
    input  logic                                pull,
    input  logic                                push,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]   wb_tag,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]   fill_tag,
    output logic                                rstrobe_d,
    input  logic [3:0]                          dwrite,
    output logic                                wstrobe_d,
    output logic [3:0]                          dread,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_cs,
    output logic                                mem_oe,
    output logic [3:0]                          mem_dout,
    input  logic [3:0]                          mem_din,
    input  logic                                mem_rdy
);

    localparam int LOG_LL = $clog2(LINE_LENGTH);
    localparam int TW     = PA - LOG_LL;
    localparam int NN     = 2 * LINE_LENGTH;
    localparam int NA     = (PA + 3) / 4;
    localparam int AW     = 4 * NA;
    localparam int CW     = $clog2((NN > NA) ? NN : NA);
    localparam int BW     = $clog2(NN);
    localparam logic [CW-1:0] NN_LAST = CW'(NN - 1);
    localparam logic [CW-1:0] NA_LAST = CW'(NA - 1);
    localparam logic [3:0]    CMD_WRITE = 4'h2;
    localparam logic [3:0]    CMD_READ  = 4'h3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WB_CAP,
        S_WB_CMD,
        S_WB_ADDR,
        S_WB_DATA,
        S_CS_GAP,
        S_FILL_CMD,
        S_FILL_ADDR,
        S_FILL_DATA,
        S_FILL_GAP,
        S_FILL_BURST,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [TW-1:0]   wb_tag_reg, fill_tag_reg;

    logic [3:0]      line_buf [NN];
    logic [3:0]      rd_data_reg;
    logic            buf_we;
    logic [BW-1:0]   buf_waddr;
    logic [3:0]      buf_wdata;

    logic [AW-1:0]   wb_addr, fill_addr;
    logic [3:0]      wb_nib   [NA];
    logic [3:0]      fill_nib [NA];

    assign wb_addr   = AW'({wb_tag_reg,   {LOG_LL{1'b0}}});
    assign fill_addr = AW'({fill_tag_reg, {LOG_LL{1'b0}}});

    // Address nibbles are sent most significant first.
    genvar gi;
    generate
        for (gi = 0; gi < NA; gi++) begin : g_addr_nib
            assign wb_nib[gi]   = wb_addr[4*(NA-1-gi) +: 4];
            assign fill_nib[gi] = fill_addr[4*(NA-1-gi) +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            wb_tag_reg   <= '0;
            fill_tag_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == S_IDLE && req && pull) begin
                wb_tag_reg   <= wb_tag;
                fill_tag_reg <= fill_tag;
            end
        end
    end

    // Read address is the next cycle's counter, so the registered read lines up with
    // the nibble the following state presents.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_waddr] <= buf_wdata;
        end
        rd_data_reg <= line_buf[cnt_next[BW-1:0]];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        buf_we     = 1'b0;
        buf_waddr  = cnt_reg[BW-1:0];
        buf_wdata  = dwrite;
        rstrobe_d  = 1'b0;
        wstrobe_d  = 1'b0;
        dread      = 4'h0;
        busy       = (state_reg != S_IDLE);
        done       = 1'b0;
        mem_cs     = 1'b0;
        mem_oe     = 1'b0;
        mem_dout   = 4'h0;

        case (state_reg)
            S_IDLE: begin
                if (req && pull) begin
                    state_next = push ? S_WB_CAP : S_FILL_CMD;
                    cnt_next   = '0;
                end
            end
            S_WB_CAP: begin
                rstrobe_d = 1'b1;
                buf_we    = 1'b1;
                if (cnt_reg == NN_LAST) begin
                    state_next = S_WB_CMD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_WB_CMD: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_dout = CMD_WRITE;
                if (mem_rdy) begin
                    state_next = S_WB_ADDR;
                    cnt_next   = '0;
                end
            end
            S_WB_ADDR: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_dout = wb_nib[cnt_reg];
                if (mem_rdy) begin
                    if (cnt_reg == NA_LAST) begin
                        state_next = S_WB_DATA;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_WB_DATA: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_dout = rd_data_reg;
                if (mem_rdy) begin
                    if (cnt_reg == NN_LAST) begin
                        state_next = S_CS_GAP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_CS_GAP: begin
                state_next = S_FILL_CMD;
                cnt_next   = '0;
            end
            S_FILL_CMD: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_dout = CMD_READ;
                if (mem_rdy) begin
                    state_next = S_FILL_ADDR;
                    cnt_next   = '0;
                end
            end
            S_FILL_ADDR: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_dout = fill_nib[cnt_reg];
                if (mem_rdy) begin
                    if (cnt_reg == NA_LAST) begin
                        state_next = S_FILL_DATA;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_FILL_DATA: begin
                mem_cs    = 1'b1;
                buf_wdata = mem_din;
                if (mem_rdy) begin
                    buf_we = 1'b1;
                    if (cnt_reg == NN_LAST) begin
                        state_next = S_FILL_GAP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_FILL_GAP: begin
                state_next = S_FILL_BURST;
                cnt_next   = '0;
            end
            S_FILL_BURST: begin
                wstrobe_d = 1'b1;
                dread     = rd_data_reg;
                if (cnt_reg == NN_LAST) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_mem.sv
// Self-checking bench for dcache_mem: a small external-memory/cache model drives the block and a
// scoreboard of expected memory-bus and fill nibbles is consumed as the block produces them.
module tb_dcache_mem;

    localparam int LL       = 4;
    localparam int PA       = 22;
    localparam int NN       = 2 * LL;
    localparam int NA       = (PA + 3) / 4;
    localparam int TW       = PA - 2;
    localparam int LAT_FILL = 1 + NA + NN + 1 + NN + 1;
    localparam int LAT_WB   = NN + 1 + NA + NN + 1;

    localparam int M_NORMAL   = 0;
    localparam int M_STALL    = 1;
    localparam int M_SCRAMBLE = 2;
    localparam int M_HOLD     = 3;
    localparam int M_ABORT    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req, pull, push;
    logic [TW-1:0] wb_tag, fill_tag;
    logic          rstrobe_d, wstrobe_d, busy, done, mem_cs, mem_oe, mem_rdy;
    logic [3:0]    dwrite, dread, mem_dout, mem_din;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    logic [3:0] exp_dout_q [$];
    logic [3:0] exp_dread_q[$];

    always #5 clk = ~clk;

    dcache_mem #(.LINE_LENGTH(LL), .PA(PA)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .pull      (pull),
        .push      (push),
        .wb_tag    (wb_tag),
        .fill_tag  (fill_tag),
        .rstrobe_d (rstrobe_d),
        .dwrite    (dwrite),
        .wstrobe_d (wstrobe_d),
        .dread     (dread),
        .busy      (busy),
        .done      (done),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_rdy   (mem_rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] addr_nib(input logic [TW-1:0] tag, input int k);
        logic [23:0] a;
        a = {2'b00, tag, 2'b00};
        return a[4*(NA-1-k) +: 4];
    endfunction

    function automatic logic [13:0] all_outs();
        return {busy, done, rstrobe_d, wstrobe_d, mem_cs, mem_oe, mem_dout, dread};
    endfunction

    // Called at a negedge; the following posedge is the start edge.
    task automatic do_txn(input logic p, input logic [TW-1:0] wt, input logic [TW-1:0] ft,
                          input logic [31:0] line, input logic [31:0] mdata, input int mode);
        int ri, di, hs, done_k, rdy_pat, viol;
        int r_cycles, r_runs, w_cycles, w_runs, cs_rises;
        logic prev_r, prev_w, prev_cs, finished, aborted;
        logic [3:0] e;

        exp_dout_q.delete();
        exp_dread_q.delete();
        if (p) begin
            exp_dout_q.push_back(4'h2);
            for (int k = 0; k < NA; k++) exp_dout_q.push_back(addr_nib(wt, k));
            for (int k = 0; k < NN; k++) exp_dout_q.push_back(line[4*k +: 4]);
        end
        exp_dout_q.push_back(4'h3);
        for (int k = 0; k < NA; k++) exp_dout_q.push_back(addr_nib(ft, k));
        for (int k = 0; k < NN; k++) exp_dread_q.push_back(mdata[4*k +: 4]);

        req = 1'b1; pull = 1'b1; push = p; wb_tag = wt; fill_tag = ft; mem_rdy = 1'b1;
        ri = 0; di = 0; hs = 0; done_k = -1; rdy_pat = 0; viol = 0;
        r_cycles = 0; r_runs = 0; w_cycles = 0; w_runs = 0; cs_rises = 0;
        prev_r = 1'b0; prev_w = 1'b0; prev_cs = 1'b0; finished = 1'b0; aborted = 1'b0;
        txn_no++;

        for (int k = 0; k < 600 && !finished; k++) begin
            @(negedge clk);
            if (mode == M_SCRAMBLE) begin
                req = 1'($urandom); pull = 1'($urandom); push = 1'($urandom);
                wb_tag = TW'($urandom); fill_tag = TW'($urandom);
            end else if (mode != M_HOLD) begin
                req = 1'b0;
            end
            if (mode == M_STALL) begin
                mem_rdy = (rdy_pat % 4 == 0) || (rdy_pat % 4 == 3);
                rdy_pat++;
            end else begin
                mem_rdy = 1'b1;
            end

            if (rstrobe_d && wstrobe_d) viol++;
            if (mem_oe && !mem_cs) viol++;
            if (!busy) viol++;

            if (rstrobe_d) begin
                if (!prev_r) r_runs++;
                r_cycles++;
                dwrite = line[4*ri +: 4];
                ri++;
            end else begin
                dwrite = 4'($urandom);
            end
            if (mem_cs && !prev_cs) cs_rises++;

            if (mem_cs && mem_oe && mem_rdy) begin
                hs++;
                if (exp_dout_q.size() == 0) begin
                    check("dout_queue", exp_dout_q.size(), 1);
                end else begin
                    e = exp_dout_q.pop_front();
                    check("mem_dout", mem_dout, e);
                end
                if (mode == M_ABORT && hs == 1 + NA + 3) begin
                    reset = 1'b1;
                    aborted = 1'b1;
                    finished = 1'b1;
                end
            end
            if (mem_cs && !mem_oe && mem_rdy) begin
                mem_din = mdata[4*di +: 4];
                di++;
            end else begin
                mem_din = 4'($urandom);
            end

            if (wstrobe_d) begin
                if (!prev_w) w_runs++;
                w_cycles++;
                if (exp_dread_q.size() == 0) begin
                    check("dread_queue", exp_dread_q.size(), 1);
                end else begin
                    e = exp_dread_q.pop_front();
                    check("dread", dread, e);
                end
            end
            if (done) begin
                done_k = k;
                finished = 1'b1;
            end
            prev_r = rstrobe_d; prev_w = wstrobe_d; prev_cs = mem_cs;
        end

        if (aborted) begin
            @(negedge clk);
            check("abort_outs", all_outs(), 0);
            reset = 1'b0;
            req = 1'b0;
            exp_dout_q.delete();
            exp_dread_q.delete();
            $display("txn %0d push=%0b wb_tag=%05h fill_tag=%05h mode=%0d aborted by reset",
                     txn_no, p, wt, ft, mode);
            return;
        end

        check("done_seen", (done_k >= 0), 1);
        if (mode != M_STALL)
            check("latency", done_k + 1, p ? LAT_FILL + LAT_WB : LAT_FILL);
        @(negedge clk);
        if (mode != M_HOLD) req = 1'b0;
        check("post_done", {busy, done, mem_cs, rstrobe_d, wstrobe_d}, 0);
        check("dout_left", exp_dout_q.size(), 0);
        check("dread_left", exp_dread_q.size(), 0);
        check("rstrobe_cycles", r_cycles, p ? NN : 0);
        check("rstrobe_runs", r_runs, p ? 1 : 0);
        check("wstrobe_cycles", w_cycles, NN);
        check("wstrobe_runs", w_runs, 1);
        check("fill_nibbles", di, NN);
        check("cs_rises", cs_rises, p ? 2 : 1);
        check("violations", viol, 0);
        $display("txn %0d push=%0b wb_tag=%05h fill_tag=%05h mode=%0d latency=%0d",
                 txn_no, p, wt, ft, mode, done_k + 1);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; pull = 1'b0; push = 1'b0;
        wb_tag = '0; fill_tag = '0; dwrite = 4'h0; mem_din = 4'h0; mem_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        // Fill only, address 0x048D14 on the bus.
        do_txn(1'b0, 20'h00000, 20'h12345, 32'h0, 32'hA5C39E71, M_NORMAL);
        // Victim writeback then fill.
        do_txn(1'b1, 20'h00010, 20'h0BEEF, 32'h87654321, 32'h13579BDF, M_NORMAL);
        // mem_rdy toggling 1-0-0-1.
        do_txn(1'b0, 20'h00000, 20'hFEDCB, 32'h0, 32'h2468ACE0, M_STALL);
        do_txn(1'b1, 20'h55AA5, 20'h0F0F0, 32'hCAFEF00D, 32'h76543210, M_STALL);
        // Reset during the writeback data phase, then a clean transaction.
        do_txn(1'b1, 20'h00ABC, 20'h00DEF, 32'h11223344, 32'h99887766, M_ABORT);
        do_txn(1'b0, 20'h00000, 20'h3C3C3, 32'h0, 32'hDEADBEEF, M_NORMAL);

        // req without pull must not start anything.
        req = 1'b1; pull = 1'b0; push = 1'b1;
        repeat (3) @(negedge clk);
        check("req_no_pull", {busy, mem_cs, rstrobe_d}, 0);
        req = 1'b0; push = 1'b0;

        // Inputs scrambled while busy; latched tags must be used.
        do_txn(1'b1, 20'h1A2B3, 20'h4C5D6, 32'h0F1E2D3C, 32'h4B5A6978, M_SCRAMBLE);
        do_txn(1'b0, 20'h00000, 20'h77777, 32'h0, 32'h31415926, M_SCRAMBLE);

        // Back-to-back misses with req&&pull held through done.
        do_txn(1'b0, 20'h00000, 20'h00123, 32'h0, 32'h0BADCAFE, M_HOLD);
        do_txn(1'b1, 20'h00456, 20'h00789, 32'hFACEB00C, 32'h12345678, M_NORMAL);

        for (int i = 0; i < 4; i++) begin
            do_txn(1'($urandom), TW'($urandom), TW'($urandom), $urandom, $urandom, M_NORMAL);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
